alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle control unit that owns the accumulator and the flags register and drives the 8-bit ALU.
- Accepts one instruction (opcode plus 8-bit operand) per valid/ready handshake.
- Maps the opcode onto the ALU control lines (Opsel, input/output inversion, carry-in) and sequences operand load, execute and write-back around the ALU's negedge-registered result.
- Sits between instruction fetch/decode and the ALU datapath.

## Interface
Parameters:
- RESET_ACC, 8'h00, accumulator value after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  sequencer can accept an instruction.
- in_op_i  in  4  opcode.
- in_operand_i  in  8  immediate operand.
- acc_o  out  8  accumulator; drives ALU A.
- alu_x_o  out  8  ALU X operand.
- alu_opsel_o  out  3  ALU Opsel: 000 AND, 001 XOR, 010 ADD, 011 SHR.
- alu_a_inv_o, alu_x_inv_o, alu_op_inv_o  out  1 each  ALU inversion controls.
- alu_carry_o  out  1  ALU Carrybit.
- alu_z_i  in  8  ALU result Z.
- alu_flags_i  in  8  ALU Flags; bit0 carry, bit4 aux carry.
- flags_o  out  8  S=7, Z=6, AC=4, P=2, C=0; other bits are 0.
- done_o  out  1  one-cycle pulse on write-back or LDA completion.
- err_o  out  1  one-cycle pulse on an illegal opcode.
- busy_o  out  1  high whenever the FSM is not in IDLE.

## Operation
Opcodes:
- 0 AND: Opsel 000.
- 1 OR: Opsel 000 with A_inv, X_inv and OP_inv all set.
- 2 XOR: Opsel 001.
- 3 XNOR: Opsel 001 with OP_inv.
- 4 ADD: Opsel 010, carry-in 0.
- 5 SUB: Opsel 010, X_inv, carry-in 1.
- 6 INC: ADD with X=0x00, carry-in 1.
- 7 DEC: ADD with X=0xFF, carry-in 0.
- 8 SHR: Opsel 011, carry-in 0, so bit 7 of the result is 0.
- 9 NOT: XOR with X=0xFF.
- 10 ADC, 11 SBB: see Configuration.
- 12 LDA: acc <= operand; the ALU is not used.
- 13-15: illegal.

FSM states: IDLE, EXEC, WB.
- IDLE: in_ready_o=1. On in_valid_i:
  - LDA: load acc, update flags, pulse done_o, stay in IDLE.
  - Illegal opcode: pulse err_o; acc and flags unchanged; stay in IDLE.
  - Otherwise: latch op and operand, go to EXEC.
- EXEC: drive alu_x_o and the control word. The ALU captures Z on the negedge within this cycle. Go to WB.
- WB: hold the control word. Sample alu_z_i into acc, update flags, pulse done_o, go to IDLE.

Flag rules, applied on each write:
- S = result[7].
- Z = (result == 0).
- P = 1 when the result has even parity.
- ADD/SUB/INC/DEC/ADC/SBB: C = alu_flags_i[0], AC = alu_flags_i[4], sampled in WB.
- Logic ops: C and AC cleared.
- SHR: C = acc[0] before the shift; AC cleared.
- LDA: updates S, Z and P; leaves C and AC unchanged.

Subtraction convention: C=1 means no borrow.

## Timing
- Reset values: acc_o=RESET_ACC; flags_o=0; alu_x_o=0; all ALU controls 0; done_o=0; err_o=0; busy_o=0; in_ready_o=1; FSM in IDLE.
- ALU op latency: accept edge T, done_o high in the cycle after edge T+2, acc_o valid at the same time.
- Throughput: one ALU op per 3 cycles. LDA and illegal opcodes complete in 1 cycle.
- in_ready_o is low in EXEC and WB. in_valid_i asserted while not ready is ignored; the source holds it until accepted.
- Control outputs stay stable from EXEC through WB so that alu_flags_i, which depends combinationally on Opsel, is valid when sampled.
- rst_n asserted mid-operation: the in-flight op is dropped and all outputs return to reset values asynchronously.

## Configuration
ALU_SEQ_CARRY_CHAIN_EN:
- Defined: ADC = ADD with carry-in = flags C; SBB = SUB with X_inv and carry-in = flags C. Flags follow the add rules.
- Undefined: opcodes 10 and 11 are illegal (err_o pulse).

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams;
  - FSM state enum;
  - flag bit indices;
  - Opsel encodings;
  - a control-word struct {opsel, a_inv, x_inv, op_inv, carry, x_sel}.
- Sub-module alu_seq_decode: combinational map from opcode and C flag to control word, is_lda and illegal.

## Test plan
- Reset, LDA 0x3C, ADD 0xC8 -> acc 0x04, C=1, Z=0, P=0; done_o 2 cycles after accept.
- LDA 0x05, SUB 0x05 -> acc 0x00, Z=1, C=1, P=1, S=0.
- LDA 0xF0, OR 0x0F -> 0xFF, S=1, C=0. Then SHR -> 0x7F, C=1. Then NOT -> 0x80.
- Opcode 13 -> err_o pulses once, acc and flags unchanged, in_ready_o stays 1. in_valid_i held during EXEC is accepted only at return to IDLE.
- With macro defined: LDA 0xFF, INC -> 0x00, C=1; then ADC 0x20 after LDA 0x10 -> 0x31. Without macro: ADC -> err_o.
- rst_n pulsed low during EXEC of ADD -> acc=RESET_ACC, flags 0, no done_o, next instruction accepted normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM states, flag positions, ALU Opsel codes
// and the control word that alu_seq_decode hands to alu_sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_XNOR = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_ADC  = 4'd10;
    localparam logic [3:0] OP_SBB  = 4'd11;
    localparam logic [3:0] OP_LDA  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Same positions are used for flags_o and for the ALU's own flag byte.
    localparam int FLAG_C  = 0;
    localparam int FLAG_P  = 2;
    localparam int FLAG_AC = 4;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_S  = 7;

    localparam logic [2:0] OPSEL_AND = 3'b000;
    localparam logic [2:0] OPSEL_XOR = 3'b001;
    localparam logic [2:0] OPSEL_ADD = 3'b010;
    localparam logic [2:0] OPSEL_SHR = 3'b011;

    localparam logic [1:0] XSEL_OPND = 2'd0;
    localparam logic [1:0] XSEL_ZERO = 2'd1;
    localparam logic [1:0] XSEL_ONES = 2'd2;

    typedef struct packed {
        logic [2:0] opsel;
        logic       a_inv;
        logic       x_inv;
        logic       op_inv;
        logic       carry;
        logic [1:0] x_sel;
    } ctrl_t;

    // S, Z and P for a result; every other bit is left 0.
    function automatic logic [7:0] szp_flags(input logic [7:0] res);
        logic [7:0] f;
        f         = 8'h00;
        f[FLAG_S] = res[7];
        f[FLAG_Z] = (res == 8'h00);
        f[FLAG_P] = ~^res;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: opcode (plus current C flag) to ALU control word.
// Build option ALU_SEQ_CARRY_CHAIN_EN: when defined, ADC/SBB are legal and use
// the C flag as carry-in; otherwise opcodes 10 and 11 decode as illegal.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    input  logic       c_flag,
    output ctrl_t      ctrl,
    output logic       is_lda,
    output logic       illegal
);

`ifndef ALU_SEQ_CARRY_CHAIN_EN
    logic unused_c_flag;
    assign unused_c_flag = c_flag;
`endif

    // Opcode to control word; OR is built as NOT(NOT A AND NOT X).
    always_comb begin
        ctrl    = '0;
        is_lda  = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_AND:  ctrl.opsel = OPSEL_AND;
            OP_OR:   begin
                ctrl.opsel  = OPSEL_AND;
                ctrl.a_inv  = 1'b1;
                ctrl.x_inv  = 1'b1;
                ctrl.op_inv = 1'b1;
            end
            OP_XOR:  ctrl.opsel = OPSEL_XOR;
            OP_XNOR: begin
                ctrl.opsel  = OPSEL_XOR;
                ctrl.op_inv = 1'b1;
            end
            OP_ADD:  ctrl.opsel = OPSEL_ADD;
            OP_SUB:  begin
                ctrl.opsel = OPSEL_ADD;
                ctrl.x_inv = 1'b1;
                ctrl.carry = 1'b1;
            end
            OP_INC:  begin
                ctrl.opsel = OPSEL_ADD;
                ctrl.x_sel = XSEL_ZERO;
                ctrl.carry = 1'b1;
            end
            OP_DEC:  begin
                ctrl.opsel = OPSEL_ADD;
                ctrl.x_sel = XSEL_ONES;
            end
            OP_SHR:  ctrl.opsel = OPSEL_SHR;
            OP_NOT:  begin
                ctrl.opsel = OPSEL_XOR;
                ctrl.x_sel = XSEL_ONES;
            end
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            OP_ADC:  begin
                ctrl.opsel = OPSEL_ADD;
                ctrl.carry = c_flag;
            end
            OP_SBB:  begin
                ctrl.opsel = OPSEL_ADD;
                ctrl.x_inv = 1'b1;
                ctrl.carry = c_flag;
            end
`endif
            OP_LDA:  is_lda = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: owns the accumulator and flags and sequences the 8-bit ALU
// around its falling-edge result register. ADC/SBB availability follows the
// ALU_SEQ_CARRY_CHAIN_EN build option (see alu_seq_decode).
//
// state | meaning
// IDLE  | ready; LDA and illegal opcodes complete here in one cycle
// EXEC  | X and control word driven; ALU captures Z on the falling edge
// WB    | control word held; Z and ALU flags written to acc/flags
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [7:0] RESET_ACC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [3:0] in_op_i,
    input  logic [7:0] in_operand_i,
    output logic [7:0] acc_o,
    output logic [7:0] alu_x_o,
    output logic [2:0] alu_opsel_o,
    output logic       alu_a_inv_o,
    output logic       alu_x_inv_o,
    output logic       alu_op_inv_o,
    output logic       alu_carry_o,
    input  logic [7:0] alu_z_i,
    input  logic [7:0] alu_flags_i,
    output logic [7:0] flags_o,
    output logic       done_o,
    output logic       err_o,
    output logic       busy_o
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_dec, ctrl_q;
    logic       dec_is_lda, dec_illegal;
    logic [7:0] operand_q, acc_q, flags_q;
    logic [7:0] x_val, flags_wb, flags_lda;
    logic       do_lda, do_err, do_launch, do_wb;
    logic       done_q, err_q, active;
    logic [5:0] unused_alu_flags;

    assign unused_alu_flags = {alu_flags_i[7:5], alu_flags_i[3:1]};

    alu_seq_decode u_decode (
        .op      (in_op_i),
        .c_flag  (flags_q[FLAG_C]),
        .ctrl    (ctrl_dec),
        .is_lda  (dec_is_lda),
        .illegal (dec_illegal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and the per-cycle action strobes.
    always_comb begin
        state_d   = state_q;
        do_lda    = 1'b0;
        do_err    = 1'b0;
        do_launch = 1'b0;
        do_wb     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    if (dec_is_lda)       do_lda = 1'b1;
                    else if (dec_illegal) do_err = 1'b1;
                    else begin
                        do_launch = 1'b1;
                        state_d   = ST_EXEC;
                    end
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                do_wb   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the decoded control word and operand at accept; held through WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            operand_q <= 8'h00;
        end else if (do_launch) begin
            ctrl_q    <= ctrl_dec;
            operand_q <= in_operand_i;
        end
    end

    // X operand source: immediate or a fixed constant for INC/DEC/NOT.
    always_comb begin
        x_val = operand_q;
        case (ctrl_q.x_sel)
            XSEL_ZERO: x_val = 8'h00;
            XSEL_ONES: x_val = 8'hFF;
            default:   x_val = operand_q;
        endcase
    end

    // ALU controls are forced to 0 in IDLE so reset clears them asynchronously.
    assign active       = (state_q != ST_IDLE);
    assign busy_o       = active;
    assign in_ready_o   = ~active;
    assign alu_x_o      = active ? x_val          : 8'h00;
    assign alu_opsel_o  = active ? ctrl_q.opsel  : 3'b000;
    assign alu_a_inv_o  = active & ctrl_q.a_inv;
    assign alu_x_inv_o  = active & ctrl_q.x_inv;
    assign alu_op_inv_o = active & ctrl_q.op_inv;
    assign alu_carry_o  = active & ctrl_q.carry;

    // New flag byte for write-back and for LDA; op class follows Opsel.
    always_comb begin
        flags_wb = szp_flags(alu_z_i);
        case (ctrl_q.opsel)
            OPSEL_ADD: begin
                flags_wb[FLAG_C]  = alu_flags_i[FLAG_C];
                flags_wb[FLAG_AC] = alu_flags_i[FLAG_AC];
            end
            OPSEL_SHR: flags_wb[FLAG_C] = acc_q[0];
            default:   ;
        endcase
        flags_lda          = szp_flags(in_operand_i);
        flags_lda[FLAG_C]  = flags_q[FLAG_C];
        flags_lda[FLAG_AC] = flags_q[FLAG_AC];
    end

    // Accumulator, flags and the registered done/err pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= RESET_ACC;
            flags_q <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= do_lda | do_wb;
            err_q  <= do_err;
            if (do_lda) begin
                acc_q   <= in_operand_i;
                flags_q <= flags_lda;
            end else if (do_wb) begin
                acc_q   <= alu_z_i;
                flags_q <= flags_wb;
            end
        end
    end

    assign acc_o   = acc_q;
    assign flags_o = flags_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam logic [7:0] TB_RESET_ACC = 8'h5A;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [3:0] in_op_i;
    logic [7:0] in_operand_i;
    logic [7:0] acc_o, alu_x_o, alu_z_i, alu_flags_i, flags_o;
    logic [2:0] alu_opsel_o;
    logic       alu_a_inv_o, alu_x_inv_o, alu_op_inv_o, alu_carry_o;
    logic       done_o, err_o, busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit run     = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.RESET_ACC(TB_RESET_ACC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_op_i      (in_op_i),
        .in_operand_i (in_operand_i),
        .acc_o        (acc_o),
        .alu_x_o      (alu_x_o),
        .alu_opsel_o  (alu_opsel_o),
        .alu_a_inv_o  (alu_a_inv_o),
        .alu_x_inv_o  (alu_x_inv_o),
        .alu_op_inv_o (alu_op_inv_o),
        .alu_carry_o  (alu_carry_o),
        .alu_z_i      (alu_z_i),
        .alu_flags_i  (alu_flags_i),
        .flags_o      (flags_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    // ---------------- ALU environment model ----------------
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] x,
                                           input logic [2:0] sel, input logic ai,
                                           input logic xi, input logic oi, input logic cin);
        logic [7:0] a1, x1, r;
        logic [8:0] s;
        logic       co, ac;
        a1 = ai ? ~a : a;
        x1 = xi ? ~x : x;
        r = 8'h00; co = 1'b0; ac = 1'b0;
        case (sel)
            3'b000: r = a1 & x1;
            3'b001: r = a1 ^ x1;
            3'b010: begin
                s  = {1'b0, a1} + {1'b0, x1} + {8'b0, cin};
                r  = s[7:0];
                co = s[8];
                ac = (int'(a1[3:0]) + int'(x1[3:0]) + int'(cin)) > 15;
            end
            3'b011: begin
                r  = {cin, a1[7:1]};
                co = a1[0];
            end
            default: r = 8'h00;
        endcase
        if (oi) r = ~r;
        return {3'b000, ac, 3'b000, co, r};
    endfunction

    logic [15:0] alu_now;
    logic [7:0]  alu_z_q = 8'h00;
    assign alu_now     = alu_fn(acc_o, alu_x_o, alu_opsel_o, alu_a_inv_o, alu_x_inv_o,
                                alu_op_inv_o, alu_carry_o);
    assign alu_flags_i = alu_now[15:8];
    assign alu_z_i     = alu_z_q;
    always @(negedge clk) alu_z_q <= alu_now[7:0];

    // ---------------- reference model ----------------
    function automatic logic [7:0] szp(input logic [7:0] r);
        logic [7:0] f;
        f    = 8'h00;
        f[7] = r[7];
        f[6] = (r == 8'h00);
        f[2] = ($countones(r) % 2) == 0;
        return f;
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return (op <= 4'd9) || (op == 4'd12) || (CARRY_EN && (op == 4'd10 || op == 4'd11));
    endfunction

    // Returns {flags, acc} after an ALU opcode, from plain arithmetic.
    function automatic logic [15:0] ref_exec(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] v, input logic cin);
        logic [7:0] res, f;
        logic       c, h;
        int         ia, iv, ic;
        ia = int'(a); iv = int'(v); ic = int'(cin);
        c = 1'b0; h = 1'b0; res = 8'h00;
        case (op)
            4'd0:  res = a & v;
            4'd1:  res = a | v;
            4'd2:  res = a ^ v;
            4'd3:  res = ~(a ^ v);
            4'd4:  begin res = 8'(ia + iv); c = (ia + iv) > 255; h = (ia % 16 + iv % 16) > 15; end
            4'd5:  begin res = 8'(ia - iv); c = ia >= iv; h = (ia % 16) >= (iv % 16); end
            4'd6:  begin res = 8'(ia + 1); c = (ia == 255); h = (ia % 16) == 15; end
            4'd7:  begin res = 8'(ia - 1); c = (ia != 0); h = (ia % 16) != 0; end
            4'd8:  begin res = a >> 1; c = a[0]; end
            4'd9:  res = ~a;
            4'd10: begin
                res = 8'(ia + iv + ic); c = (ia + iv + ic) > 255;
                h = (ia % 16 + iv % 16 + ic) > 15;
            end
            4'd11: begin
                res = 8'(ia - iv - 1 + ic); c = ia >= (iv + 1 - ic);
                h = (ia % 16) >= (iv % 16 + 1 - ic);
            end
            default: res = a;
        endcase
        f    = szp(res);
        f[0] = c;
        f[4] = h;
        return {f, res};
    endfunction

    // Expected {opsel, a_inv, x_inv, op_inv, carry} for each ALU opcode.
    function automatic logic [6:0] spec_ctrl(input logic [3:0] op, input logic c);
        case (op)
            4'd0:  return 7'b000_0000;
            4'd1:  return 7'b000_1110;
            4'd2:  return 7'b001_0000;
            4'd3:  return 7'b001_0010;
            4'd4:  return 7'b010_0000;
            4'd5:  return 7'b010_0101;
            4'd6:  return 7'b010_0001;
            4'd7:  return 7'b010_0000;
            4'd8:  return 7'b011_0000;
            4'd9:  return 7'b001_0000;
            4'd10: return {6'b010_000, c};
            4'd11: return {6'b010_010, c};
            default: return 7'b000_0000;
        endcase
    endfunction

    function automatic logic [7:0] spec_x(input logic [3:0] op, input logic [7:0] v);
        if (op == 4'd6) return 8'h00;
        if (op == 4'd7 || op == 4'd9) return 8'hFF;
        return v;
    endfunction

    logic [7:0]  exp_acc = TB_RESET_ACC;
    logic [7:0]  exp_flags = 8'h00;
    logic        exp_done = 1'b0, exp_err = 1'b0;
    int          pend = 0;
    logic [3:0]  p_op = 4'd0;
    logic [7:0]  p_v = 8'h00;
    logic        p_c = 1'b0;
    logic [15:0] ref_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_acc = TB_RESET_ACC; exp_flags = 8'h00;
            exp_done = 1'b0; exp_err = 1'b0; pend = 0;
        end else begin
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (pend == 0) begin
                if (in_valid_i) begin
                    if (in_op_i == 4'd12) begin
                        exp_flags = szp(in_operand_i) | (exp_flags & 8'h11);
                        exp_acc   = in_operand_i;
                        exp_done  = 1'b1;
                    end else if (!is_legal(in_op_i)) begin
                        exp_err = 1'b1;
                    end else begin
                        pend = 2; p_op = in_op_i; p_v = in_operand_i; p_c = exp_flags[0];
                    end
                end
            end else begin
                pend = pend - 1;
                if (pend == 0) begin
                    ref_res   = ref_exec(p_op, exp_acc, p_v, p_c);
                    exp_acc   = ref_res[7:0];
                    exp_flags = ref_res[15:8];
                    exp_done  = 1'b1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] ec;
    logic [7:0] ex;
    always @(negedge clk) begin
        if (run) begin
            ec = (pend != 0) ? spec_ctrl(p_op, p_c) : 7'd0;
            ex = (pend != 0) ? spec_x(p_op, p_v) : 8'd0;
            check("acc",   acc_o,      exp_acc);
            check("flags", flags_o,    exp_flags);
            check("done",  done_o,     exp_done);
            check("err",   err_o,      exp_err);
            check("ready", in_ready_o, pend == 0);
            check("busy",  busy_o,     pend != 0);
            check("ctrl",  {alu_opsel_o, alu_a_inv_o, alu_x_inv_o, alu_op_inv_o, alu_carry_o}, ec);
            check("alu_x", alu_x_o,    ex);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [3:0] op, input logic [7:0] v, output int waited);
        in_valid_i = 1'b1; in_op_i = op; in_operand_i = v;
        waited = 0;
        while (pend != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got busy expected ready at %0t", $time);
        end else begin
            @(negedge clk);
        end
        in_valid_i = 1'b0;
    endtask

    int w;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid_i = 1'b0; in_op_i = 4'd0; in_operand_i = 8'h00;
        repeat (3) @(negedge clk);
        run = 1'b1;
        check("rst_acc", acc_o, 8'h5A);
        check("rst_flags", flags_o, 8'h00);
        check("rst_ready", in_ready_o, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // LDA 0x3C, ADD 0xC8 -> 0x04, C=1 AC=1; done two cycles after accept
        send(4'd12, 8'h3C, w);
        send(4'd4, 8'hC8, w);
        check("add_done_t0", done_o, 1'b0);
        @(negedge clk);
        check("add_done_t1", done_o, 1'b0);
        @(negedge clk);
        check("add_done_t2", done_o, 1'b1);
        check("add_acc", acc_o, 8'h04);
        check("add_flags", flags_o, 8'h11);
        check("model_add", {exp_flags, exp_acc}, 16'h1104);

        // LDA 5, SUB 5 -> 0, Z P C AC set
        send(4'd12, 8'h05, w);
        send(4'd5, 8'h05, w);
        repeat (2) @(negedge clk);
        check("sub_acc", acc_o, 8'h00);
        check("sub_flags", flags_o, 8'h55);

        // LDA F0, OR 0F -> FF; SHR -> 7F C=1; NOT -> 80
        send(4'd12, 8'hF0, w);
        send(4'd1, 8'h0F, w);
        repeat (2) @(negedge clk);
        check("or_res", {flags_o, acc_o}, 16'h84FF);
        send(4'd8, 8'h00, w);
        repeat (2) @(negedge clk);
        check("shr_res", {flags_o, acc_o}, 16'h017F);
        send(4'd9, 8'h00, w);
        repeat (2) @(negedge clk);
        check("not_res", {flags_o, acc_o}, 16'h8080);
        check("model_not", {exp_flags, exp_acc}, 16'h8080);

        // illegal opcode 13
        send(4'd13, 8'h77, w);
        check("ill_err", err_o, 1'b1);
        check("ill_ready", in_ready_o, 1'b1);
        check("ill_keep", {flags_o, acc_o}, 16'h8080);
        @(negedge clk);
        check("ill_err_pulse", err_o, 1'b0);

        // back-to-back: second instruction held through EXEC/WB
        send(4'd4, 8'h01, w);
        send(4'd2, 8'hFF, w);
        check("hold_wait", w, 2);
        repeat (2) @(negedge clk);
        check("hold_res", acc_o, 8'h7E);

`ifdef ALU_SEQ_CARRY_CHAIN_EN
        send(4'd12, 8'hFF, w);
        send(4'd6, 8'h00, w);
        repeat (2) @(negedge clk);
        check("inc_res", {flags_o, acc_o}, 16'h5500);
        send(4'd12, 8'h10, w);
        send(4'd10, 8'h20, w);
        repeat (2) @(negedge clk);
        check("adc_res", {flags_o, acc_o}, 16'h0031);
`else
        send(4'd10, 8'h20, w);
        check("adc_err", err_o, 1'b1);
`endif

        // reset while ADD is in EXEC
        send(4'd4, 8'h11, w);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_acc", acc_o, 8'h5A);
        check("mid_rst_flags", flags_o, 8'h00);
        check("mid_rst_busy", busy_o, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_nodone", done_o, 1'b0);
        @(negedge clk);
        check("mid_rst_nodone2", done_o, 1'b0);
        send(4'd12, 8'h42, w);
        check("post_rst_lda", acc_o, 8'h42);

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) op = 4'd12;
            send(op, 8'($urandom), w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
